// File: rtl/alu_pkg.sv
// Shared ALU width and ALUOp encodings for the RV64 execute stage.
package alu_pkg;

    localparam int XLEN = 64;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for SLL/SRL/SRA (dir=1 shifts right).
// Zero latency, no flow control.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int W  = XLEN,
    parameter int SW = $clog2(W)
) (
    input  logic [W-1:0]  in,
    input  logic [SW-1:0] shamt,
    input  logic          dir,
    input  logic          arith,
    output logic [W-1:0]  out
);

    always_comb begin
        out = '0;
        if (!dir) begin
            out = in << shamt;
        end else if (arith) begin
            out = $unsigned($signed(in) >>> shamt);
        end else begin
            out = in >> shamt;
        end
    end

endmodule

// File: rtl/alu.sv
// 64-bit RV64 integer ALU with registered result and zero flag.
// Latency 1 cycle; no backpressure, accepts a new op every cycle.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUOp,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SW = $clog2(XLEN);

    logic            sub;
    logic [XLEN-1:0] b_op;
    logic [XLEN:0]   sum;
    logic            overflow;
    logic            lt_signed;
    logic            lt_unsigned;
    logic [XLEN-1:0] shift_out;
    logic [XLEN-1:0] next_res;

    // Compares reuse the subtractor: A - B = A + ~B + 1.
    assign sub  = (ALUOp == ALU_SUB) || (ALUOp == ALU_SLT) || (ALUOp == ALU_SLTU);
    assign b_op = sub ? ~B : B;
    assign sum  = {1'b0, A} + {1'b0, b_op} + {{XLEN{1'b0}}, sub};

    // No carry out of A + ~B + 1 means a borrow, i.e. A < B unsigned.
    assign overflow    = (A[XLEN-1] != B[XLEN-1]) && (sum[XLEN-1] != A[XLEN-1]);
    assign lt_signed   = sum[XLEN-1] ^ overflow;
    assign lt_unsigned = ~sum[XLEN];

    alu_shifter #(.W(XLEN), .SW(SW)) u_shifter (
        .in    (A),
        .shamt (B[SW-1:0]),
        .dir   (ALUOp != ALU_SLL),
        .arith (ALUOp == ALU_SRA),
        .out   (shift_out)
    );

    always_comb begin
        next_res = '0;
        case (ALUOp)
            ALU_AND:  next_res = A & B;
            ALU_OR:   next_res = A | B;
            ALU_XOR:  next_res = A ^ B;
            ALU_ADD,
            ALU_SUB:  next_res = sum[XLEN-1:0];
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  next_res = shift_out;
            ALU_SLT:  next_res = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: next_res = {{(XLEN-1){1'b0}}, lt_unsigned};
            default:  next_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= next_res;
            zero   <= (next_res == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: literal directed cases plus randomized ops
// compared every cycle against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [3:0]      ALUOp;
    logic [XLEN-1:0] result;
    logic            zero;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [XLEN-1:0] exp_res  = '0;
    logic            exp_zero = 1'b1;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .ALUOp  (ALUOp),
        .result (result),
        .zero   (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] op);
        int sh;
        sh = int'(b % 64);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a ^ b;
            4'b0100: return a << sh;
            4'b0101: return a >> sh;
            4'b1101: return $unsigned($signed(a) >>> sh);
            4'b0111: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'b1000: return (a < b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one-cycle delayed outputs, async clear on reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_res  <= '0;
            exp_zero <= 1'b1;
        end else begin
            exp_res  <= model(A, B, ALUOp);
            exp_zero <= (model(A, B, ALUOp) == 64'd0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_result", result, exp_res);
            chk("cyc_zero", {63'd0, zero}, {63'd0, exp_zero});
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [63:0] lit, input string name);
        A     = a;
        B     = b;
        ALUOp = op;
        @(posedge clk);
        @(negedge clk);
        chk(name, result, lit);
        chk({name, "_zero"}, {63'd0, zero}, {63'd0, lit == 64'd0});
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 130));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        A     = 64'd5;
        B     = 64'd3;
        ALUOp = ALU_ADD;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_en = 1;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 64'd0);
        chk("reset_zero", {63'd0, zero}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_add", result, 64'd8);
        chk("post_reset_zero", {63'd0, zero}, 64'd0);

        // Directed sequence, a new op every cycle.
        issue(64'd10, 64'd10, ALU_ADD, 64'd20, "add_10_10");
        issue(64'd30, 64'd10, ALU_ADD, 64'd40, "add_30_10");
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'd0, "add_wrap");
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'h8000_0000_0000_0000, "add_ovf");
        issue(64'd30, 64'd10, ALU_SUB, 64'd20, "sub_30_10");
        issue(64'd10, 64'd10, ALU_SUB, 64'd0, "sub_10_10");
        issue(64'd0, 64'd1, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFFF, "sub_0_1");
        issue(64'hFFC, 64'h7, ALU_AND, 64'h4, "and");
        issue(64'hFFC, 64'h7, ALU_OR, 64'hFFF, "or");
        issue(64'hFFC, 64'h7, ALU_XOR, 64'hFFB, "xor");
        issue(64'hFFC, 64'h7, 4'b1111, 64'd0, "unused_op");
        issue(64'h8000_0000_0000_0001, 64'd1, ALU_SLL, 64'h2, "sll_1");
        issue(64'h8000_0000_0000_0001, 64'd63, ALU_SRL, 64'h1, "srl_63");
        issue(64'h8000_0000_0000_0001, 64'd4, ALU_SRA, 64'hF800_0000_0000_0000, "sra_4");
        issue(64'h8000_0000_0000_0001, 64'h40, ALU_SRA, 64'h8000_0000_0000_0001, "sra_sh0");
        issue(64'h8000_0000_0000_0001, 64'h40, ALU_SLL, 64'h8000_0000_0000_0001, "sll_sh0");
        issue(64'h8000_0000_0000_0000, 64'd0, ALU_SLT, 64'd1, "slt_neg");
        issue(64'h8000_0000_0000_0000, 64'd0, ALU_SLTU, 64'd0, "sltu_big");
        issue(64'd3, 64'd5, ALU_SLT, 64'd1, "slt_3_5");
        issue(64'd3, 64'd5, ALU_SLTU, 64'd1, "sltu_3_5");
        issue(64'd5, 64'd3, ALU_SLT, 64'd0, "slt_5_3");

        // Randomized back-to-back ops; the per-cycle compare does the checking.
        for (int i = 0; i < 400; i++) begin
            A = pick();
            B = pick();
            ALUOp = 4'($urandom_range(0, 15));
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1;
                chk("mid_reset_result", result, 64'd0);
                chk("mid_reset_zero", {63'd0, zero}, 64'd1);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                // Operand glitch between edges must not reach the outputs.
                if (i % 7 == 3) begin
                    #2 A = ~A;
                    #1 A = ~A;
                end
                @(negedge clk);
            end
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
